regfile_write_arbiter: RTL
==========================

# regfile_write_arbiter

Sequencer and arbiter for the register file's single write port (WE3/A3/WD3). After every reset it sweeps zeros into registers 1..REG_COUNT-1. It then shares the port between the core writeback path and a debug/loader requester, with bounded debug starvation. It sits between the writeback stage and the register file; both read ports bypass it.

## Interface
- DATA_WIDTH, 32, register width
- ADDR_WIDTH, 5, register address width
- REG_COUNT, 32, registers swept by init; must be ≤ 2^ADDR_WIDTH
- MAX_WAIT, 3, consecutive lost cycles before debug gets forced priority; ≥1
- One clock; reset is asynchronous and active-high.
- CLK  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- core_we  in  1  core writeback request, this cycle only
- core_addr  in  ADDR_WIDTH  core destination register
- core_data  in  DATA_WIDTH  core write data
- core_stall  out  1  core_we present but not granted this cycle
- dbg_req  in  1  debug write request; held until dbg_ack
- dbg_addr  in  ADDR_WIDTH  debug destination register; stable while dbg_req high
- dbg_data  in  DATA_WIDTH  debug write data; stable while dbg_req high
- dbg_ack  out  1  debug write performed this cycle
- busy_init  out  1  init sweep in progress
- WE3  out  1  register file write enable
- A3  out  ADDR_WIDTH  register file write address
- WD3  out  DATA_WIDTH  register file write data

## Operation
- State machine: INIT, RUN. Registers: state, init_ptr (ADDR_WIDTH), wait_cnt (saturating, 0..MAX_WAIT).
- rst high: state=INIT, init_ptr=1, wait_cnt=0. Outputs forced WE3=0, A3=0, WD3=0, dbg_ack=0, core_stall=0, busy_init=1.
- INIT (rst low): WE3=1, A3=init_ptr, WD3=0, busy_init=1, dbg_ack=0, core_stall=core_we. init_ptr increments each cycle. When init_ptr==REG_COUNT-1, go to RUN next edge.
- RUN: busy_init=0. dbg_pri = (wait_cnt==MAX_WAIT).
- Debug granted if dbg_req && (!core_we || dbg_pri): A3=dbg_addr, WD3=dbg_data, WE3=(dbg_addr!=0), dbg_ack=1, core_stall=core_we.
- Otherwise core granted if core_we: A3=core_addr, WD3=core_data, WE3=(core_addr!=0), core_stall=0, dbg_ack=0.
- Otherwise idle: WE3=0, A3=0, WD3=0.
- Writes to x0 are dropped (WE3=0). They are still granted and acknowledged.
- wait_cnt: cleared when debug is granted or dbg_req is low. Incremented, saturating at MAX_WAIT, when dbg_req is high and core wins. Held in INIT.

## Timing
- All outputs are combinational from state and current inputs. The register file commits on the same CLK edge that ends the grant cycle.
- Init sweep takes exactly REG_COUNT-1 cycles after rst deassert: cycle k drives A3=k+1. First RUN cycle is cycle REG_COUNT-1.
- Debug latency with core idle: 0 cycles; dbg_ack is high in the first cycle dbg_req is seen.
- Worst-case debug latency under continuous core_we: MAX_WAIT lost cycles, then a grant in cycle MAX_WAIT+1.
- dbg_ack is one cycle per write. If dbg_req stays high after an ack, the next cycle is a new request (back-to-back writes allowed, wait_cnt starts from 0).
- Core has no retry queue. The core holds or replays its write while core_stall=1.
- rst mid-INIT restarts the sweep at register 1. rst mid-RUN drops any pending debug request (no ack); the requester re-issues after init.
- rst deasserted with requests high: they are stalled or unacked until RUN.

## Test plan
- Reset release, no requests -> busy_init=1 for 31 cycles; A3=1..31, WD3=0, WE3=1; then busy_init=0 and WE3=0.
- RUN, core_we=1, core_addr=5, core_data=0xDEADBEEF -> same cycle WE3=1, A3=5, WD3=0xDEADBEEF, core_stall=0; a later read of A1=5 returns 0xDEADBEEF.
- RUN, dbg_req=1 addr=7 data=0x1234, core idle -> dbg_ack=1 same cycle, WE3=1, A3=7; with dbg_req held, a new ack every cycle.
- RUN, core_we=1 every cycle, dbg_req=1 addr=9 -> core wins 3 cycles (core_stall=0, dbg_ack=0); 4th cycle dbg_ack=1, A3=9, core_stall=1; 5th cycle core wins again.
- Core write to addr 0 with data 0xFFFFFFFF -> WE3=0, core_stall=0; x0 reads 0. Debug write to addr 0 -> dbg_ack=1, WE3=0.
- rst pulsed at init cycle 10, then at RUN with dbg_req pending -> sweep restarts at A3=1; pending debug gets no ack until 31 cycles after release.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: owns the register file write port; zero-sweeps x1..xN after reset,
// then arbitrates core writeback against a debug requester with bounded debug starvation.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int REG_COUNT  = 32,
  parameter int MAX_WAIT   = 3
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_data,
  output logic                  core_stall,
  input  logic                  dbg_req,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_data,
  output logic                  dbg_ack,
  output logic                  busy_init,
  output logic                  WE3,
  output logic [ADDR_WIDTH-1:0] A3,
  output logic [DATA_WIDTH-1:0] WD3
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  typedef enum logic {INIT, RUN} state_t;
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_init_ptr;
  logic [WW-1:0]         r_wait_cnt;
  logic                  w_init, w_run, w_dbg_pri, w_dbg_gnt, w_core_gnt;
  always_comb begin
    w_init     = !rst && r_state == INIT;
    w_run      = !rst && r_state == RUN;
    w_dbg_pri  = r_wait_cnt == WW'(MAX_WAIT);
    w_dbg_gnt  = w_run && dbg_req && (!core_we || w_dbg_pri);
    w_core_gnt = w_run && core_we && !w_dbg_gnt;
    // x0 writes are still granted/acked, but never reach the register file
    WE3        = w_init || (w_dbg_gnt && dbg_addr != '0) || (w_core_gnt && core_addr != '0);
    A3         = w_init ? r_init_ptr : w_dbg_gnt ? dbg_addr : w_core_gnt ? core_addr : '0;
    WD3        = w_dbg_gnt ? dbg_data : w_core_gnt ? core_data : '0;
    dbg_ack    = w_dbg_gnt;
    core_stall = !rst && core_we && !w_core_gnt;
    busy_init  = rst || r_state == INIT;
  end
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_state    <= INIT;
      r_init_ptr <= ADDR_WIDTH'(1);
      r_wait_cnt <= '0;
    end else if (r_state == INIT) begin
      r_init_ptr <= r_init_ptr + 1'b1;
      if (r_init_ptr == ADDR_WIDTH'(REG_COUNT - 1)) r_state <= RUN;
    end else begin
      r_wait_cnt <= (w_dbg_gnt || !dbg_req) ? '0 : w_dbg_pri ? r_wait_cnt : r_wait_cnt + 1'b1;
    end
  end
endmodule
